// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle N-bit adder/subtractor that processes K bits per clock,
// LSB chunk first, carrying between chunks through a register. Valid/ready on both sides.
// Optional macro CHUNKED_ADDSUB_FLAGS_EN enables the registered ovf and zero flags;
// without it both outputs are tied to 0 and their logic is not generated.
module chunked_addsub #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned CHUNKS = N / K;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LastChunk = CW'(CHUNKS - 1);

  if ((N % K) != 0) begin : g_bad_width
    $error("chunked_addsub: N (%0d) must be an exact multiple of K (%0d)", N, K);
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  int unsigned   base;
  logic [K-1:0]  a_chunk, b_chunk, r;
  logic          c;
  logic          last;
  logic [N-1:0]  res_full;

  // Current chunk add and the working result with that chunk merged in
  always_comb begin
    base     = int'(cnt_q) * K;
    a_chunk  = a_q[base +: K];
    b_chunk  = b_q[base +: K];
    {c, r}   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
    last     = (cnt_q == LastChunk);
    res_full = res_q;
    res_full[base +: K] = r;
  end

  // Handshake flags decoded straight from state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Next-state: accept in IDLE, one chunk per RUN cycle, wait for consumer in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtract as A + ~B + 1: invert B here, inject the +1 as initial carry
          a_d     = in_a;
          b_d     = in_b ^ {N{in_sub}};
          carry_d = in_sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = res_full;
        carry_d = c;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // Visible outputs only change here, so no partial result ever shows
          sum_d   = res_full;
          cout_d  = c;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef CHUNKED_ADDSUB_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic c_top;

  // Carry into bit N-1 recovered from the top sum bit of the final chunk
  assign c_top = r[K-1] ^ a_chunk[K-1] ^ b_chunk[K-1];

  // Flags update together with sum on DONE entry
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if ((state_q == StRun) && last) begin
      ovf_d  = c_top ^ c;
      zero_d = (res_full == '0);
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: a 32/8 instance driven through directed steps with a
// scoreboard queue of expected results, plus an 8/8 instance for the single-chunk case.
module tb_chunked_addsub;

  localparam int unsigned CH = 4;
`ifdef CHUNKED_ADDSUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] in_a, in_b, sum;

  logic        v8, rdy8, s8, ov8, ordy8, c8, ovf8, z8;
  logic [7:0]  a8, b8, sum8;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_last = 0;
  exp_t sb[$];
  exp_t cur;

  chunked_addsub #(.N(32), .K(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  chunked_addsub #(.N(8), .K(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .in_ready  (rdy8),
    .in_a      (a8),
    .in_b      (b8),
    .in_sub    (s8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .sum       (sum8),
    .cout      (c8),
    .ovf       (ovf8),
    .zero      (z8)
  );

  always #5 clk = ~clk;

  // Edge counter; each accept edge is labelled with its own count
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_last <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    exp_t        e;
    logic [32:0] t;
    if (sub) t = {1'b0, a} - {1'b0, b};
    else     t = {1'b0, a} + {1'b0, b};
    e.sum  = t[31:0];
    // Unsigned: add carries out on wrap; subtract reports "no borrow" as 1
    e.cout = sub ? (a >= b) : t[32];
    if (sub) e.ovf = (a[31] != b[31]) && (e.sum[31] != a[31]);
    else     e.ovf = (a[31] == b[31]) && (e.sum[31] != a[31]);
    e.zero = (e.sum == 32'd0);
    e.ovf  = e.ovf & FLAGS;
    e.zero = e.zero & FLAGS;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_sum"},  64'(sum),  64'(cur.sum));
    check({tag, "_cout"}, 64'(cout), 64'(cur.cout));
    check({tag, "_ovf"},  64'(ovf),  64'(cur.ovf));
    check({tag, "_zero"}, 64'(zero), 64'(cur.zero));
  endtask

  // Present an operation at a negedge; accepted on the next posedge if idle
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input bit push);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    if (push) sb.push_back(model(a, b, sub));
  endtask

  // Scramble the port operands while the op is in flight
  task automatic junk();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_sub = ~in_sub;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(cyc - acc_last), 64'(CH));
    if (out_valid && sb.size() > 0) begin
      cur = sb.pop_front();
      check_out(tag);
    end else begin
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
    end
  endtask

  task automatic take(input string tag, input int hold, input bit keep);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_out({tag, "_hold"});
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'(0));
      check({tag, "_hold_vld"}, 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (!keep) out_ready = 1'b0;
    check({tag, "_idle_vld"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_rdy"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int a2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
    out_ready = 1'b0;
    v8 = 1'b0;
    a8 = '0;
    b8 = '0;
    s8 = 1'b0;
    ordy8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rdy",  64'(in_ready),  64'(1));
    check("rst_vld",  64'(out_valid), 64'(0));
    check("rst_sum",  64'(sum),       64'(0));
    check("rst_flag", 64'({cout, ovf, zero}), 64'(0));
    check("rst8_rdy", 64'(rdy8), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Wrapping add
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk);
    junk();
    check("wrap_busy", 64'(in_ready), 64'(0));
    wait_done("wrap");
    take("wrap", 0, 1'b0);

    // Subtract with borrow
    drive(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    @(negedge clk);
    junk();
    wait_done("subneg");
    take("subneg", 0, 1'b0);

    // Signed overflow on add
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk);
    junk();
    wait_done("addovf");
    take("addovf", 0, 1'b0);

    // Backpressure with next request held during DONE
    drive(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b1);
    @(negedge clk);
    drive(32'hAAAA_0000, 32'h0000_5555, 1'b1, 1'b1);
    check("bp_busy", 64'(in_ready), 64'(0));
    wait_done("bp");
    take("bp", 3, 1'b1);
    @(negedge clk);
    check("bp_accept", 64'(acc_last), 64'(cyc));
    check("bp_accept_rdy", 64'(in_ready), 64'(0));

    // Back-to-back with out_ready high: measure issue period
    a2 = acc_last;
    drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
    wait_done("bp_next");
    @(negedge clk);
    @(negedge clk);
    check("period", 64'(acc_last - a2), 64'(CH + 2));
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_done("period_op");
    take("period_op", 0, 1'b0);

    // Asynchronous reset two cycles into RUN
    drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld",  64'(out_valid), 64'(0));
    check("mid_rst_rdy",  64'(in_ready),  64'(1));
    check("mid_rst_sum",  64'(sum),       64'(0));
    check("mid_rst_cout", 64'(cout),      64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (CH + 1) @(negedge clk);
    check("post_rst_vld", 64'(out_valid), 64'(0));
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    @(negedge clk);
    junk();
    wait_done("post_rst");
    take("post_rst", 0, 1'b0);

    // Single-chunk instance: subtract with signed overflow
    v8 = 1'b1;
    a8 = 8'h80;
    b8 = 8'h01;
    s8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    check("n8_early_vld", 64'(ov8), 64'(0));
    @(negedge clk);
    check("n8_vld",  64'(ov8),  64'(1));
    check("n8_sum",  64'(sum8), 64'(8'h7F));
    check("n8_cout", 64'(c8),   64'(1));
    check("n8_ovf",  64'(ovf8), 64'(FLAGS));
    check("n8_zero", 64'(z8),   64'(0));
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check("n8_idle", 64'({rdy8, ov8}), 64'(2'b10));

    // Single-chunk instance: wrap to zero
    v8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'h01;
    s8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    check("n8b_vld",  64'(ov8),  64'(1));
    check("n8b_sum",  64'(sum8), 64'(0));
    check("n8b_cout", 64'(c8),   64'(1));
    check("n8b_ovf",  64'(ovf8), 64'(0));
    check("n8b_zero", 64'(z8),   64'(FLAGS));
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Multi-cycle, parametrised adder/subtractor for the femtoRV32 datapath.
- Processes an N-bit operation K bits per clock, rippling the carry between chunks through a register.
- Gives smaller area and shorter critical path than a full-width ripple adder.
- Valid/ready handshakes on both sides; serves multi-cycle ALU ops and address/offset arithmetic off the single-cycle path.

Parameters:
- N, 32, operand and result width in bits.
- K, 8, chunk width added per cycle. N must be an exact multiple of K; otherwise elaboration fails via $error in a generate check.
- CHUNKS (localparam), N/K, number of RUN cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  N  result, modulo 2^N.
- cout  output  1  carry out of bit N-1. For subtract: 1 = no borrow (A >= B unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); both decoded combinationally from state.
- Reset (rst_n low, any time, asynchronous):
  - state=IDLE, chunk counter=0, carry reg=0.
  - sum=0, cout=0, ovf=0, zero=0, out_valid=0, in_ready=1.
  - An operation in progress is aborted and discarded. No partial result is ever presented.
- IDLE, in_valid & in_ready at an edge:
  - Latch a_reg=in_a and b_reg=in_b^{N{in_sub}}; carry reg=in_sub; counter=0; go to RUN.
  - Port operands are not sampled again until the next accept.
- RUN, each edge:
  - Compute {c, r} = a_reg[chunk] + b_reg[chunk] + carry in K+1-bit arithmetic.
  - Write r into result chunk[counter]; carry<=c; counter++.
  - Chunks go LSB first.
  - On the edge processing chunk CHUNKS-1: register cout=c and ovf = (carry into bit N-1) XOR c; go to DONE.
  - zero is registered on the same edge from the full assembled result.
- Latency: out_valid rises exactly CHUNKS cycles after the accept edge.
- DONE:
  - sum/cout/ovf/zero held stable while out_valid=1 & out_ready=0 (unbounded backpressure).
  - On out_valid & out_ready, go to IDLE.
  - in_valid during DONE is ignored, including the handshake cycle; no bypass.
  - Minimum issue period: CHUNKS+2 cycles.
- Outputs keep the last result in IDLE and RUN until overwritten by the next DONE entry. Consumers must qualify with out_valid.
- in_valid/in_b changes during RUN have no effect.
- in_ready is low in RUN/DONE; a requester holding in_valid is accepted on the first IDLE edge.
- K==N is legal: CHUNKS=1, latency 1.
- Counter width: clog2(CHUNKS), minimum 1 bit.

Optional Feature:
- Macro: CHUNKED_ADDSUB_FLAGS_EN.
- Defined: ovf and zero computed and registered as above.
- Undefined: ovf and zero tied to 0, and their logic/registers are not generated.
- sum, cout and the handshake are identical in both builds.

Test Plan:
- N=32, K=8, FLAGS_EN: add 0xFFFFFFFF + 0x00000001 -> out_valid exactly 4 cycles after accept; sum=0x00000000, cout=1, zero=1, ovf=0.
- Sub 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0. Then add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cout=0.
- Backpressure: out_ready low 3 cycles after out_valid, in_valid held high with new operands.
  - Required: outputs stable, in_ready=0 throughout.
  - Next op accepted on the edge after the handshake cycle; issue period = 6 cycles.
- Reset mid-op: assert rst_n=0 asynchronously two cycles into RUN.
  - Required: immediately out_valid=0, in_ready=1, sum=0, cout=0.
  - After release, add 0x12345678 + 0x11111111 -> 0x23456789.
- Instance N=8, K=8: sub 0x80 - 0x01 -> latency 1 cycle, sum=0x7F, cout=1, ovf=1.
- Build without CHUNKED_ADDSUB_FLAGS_EN: repeat the 0x7FFFFFFF + 1 case -> sum=0x80000000, cout=0, ovf=0, zero=0.
